multi_bounce_box: RTL
=====================

# multi_bounce_box

Parametrised successor to the single bouncing-box demo: tracks `N_BOX` independent boxes on a VGA raster. Each box moves by a programmable speed once per frame and reflects off all four screen edges. The block reports registered per-box pixel hits to the colour mux of the top-level `tt_um_` wrapper. Positions update sequentially, one box per cycle, during blanking, so a single shared stepping datapath serves every box.

## Interface
- `N_BOX`, 2, number of boxes; legal range 1..8
- `H_RES`, 640, visible width in pixels
- `V_RES`, 480, visible height in pixels
- `BOX_W`, 32, box width in pixels
- `BOX_H`, 32, box height in pixels
- `COORD_W`, 10, coordinate width; must cover `H_RES` and `V_RES`
- `SPEED_W`, 3, speed field width
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ena`  in  1  design enable; when low, `frame_tick` is ignored
- `frame_tick`  in  1  one-cycle pulse at the start of vertical blank
- `pause`  in  1  when high, frame steps are skipped
- `speed`  in  `SPEED_W`  pixels per frame, both axes; sampled on `frame_tick`
- `hpos`, `vpos`  in  `COORD_W` each  current raster coordinate
- `box_hit`  out  `N_BOX`  registered; bit i high when the raster is inside box i
- `any_hit`  out  1  registered OR of `box_hit`
- `rgb`  out  3  registered colour of the lowest-index hit box; 0 when no box is hit
- `bounce_pulse`  out  `N_BOX`  one-cycle pulse when box i reverses on either axis
- `corner_pulse`  out  1  one-cycle pulse when a box reverses on both axes in the same step
- `busy`  out  1  high while the update sequence runs

## Operation
- Per-box state: `x`, `y` (`COORD_W` bits each); `dx`, `dy` (0 = +, 1 = −).
- Reset position of box i: `x = 16 + 48*i`, `y = 16 + 32*i`; `dy = 0`; `dx = i[0]`.
- FSM states:
  - IDLE: on `frame_tick && ena && !pause && speed != 0`, latch `speed`, set index = 0, go to STEP. Otherwise stay in IDLE.
  - STEP: update box[index]. If index = `N_BOX-1`, go to IDLE; otherwise index++.
- Per-axis step, using `COORD_W+1`-bit intermediates. Bound: `H_RES-BOX_W` for x, `V_RES-BOX_H` for y.
  - `+` direction: `n = p + s`. If `n >= bound`, then `p = bound`, direction flips, and the box has bounced. Otherwise `p = n`.
  - `−` direction: if `p <= s`, then `p = 0`, direction flips, and the box has bounced. Otherwise `p = p - s`.
- `frame_tick` arriving in STEP is dropped; there is no queueing.
- Hit test for box i: `x <= hpos < x+BOX_W` and `y <= vpos < y+BOX_H`. Both comparisons use current registers, including during STEP.
- `rst_n` low at any time, including mid-sequence, restores all boxes to their reset positions and directions and forces IDLE.

## Timing
- Every output resets to 0.
- `frame_tick` sampled high at edge T: `busy` is high for cycles T+1 .. T+`N_BOX`.
  - Box i's registers update at edge T+1+i.
  - `bounce_pulse[i]` and `corner_pulse` are high for the cycle following that edge.
- Hit latency: `box_hit`, `any_hit` and `rgb` reflect the `hpos`/`vpos` sampled one edge earlier.
- When only `pause` or `speed = 0` blocks a step, the frame is skipped without any pulse and `busy` stays low.

## Configuration
- `MULTI_BOUNCE_COLOR_EN` defined:
  - Each box has a 3-bit colour register, reset value `i+1` (mod 8).
  - The register increments, wrapping at 7, on every `bounce_pulse[i]`.
  - `rgb` outputs the colour of the lowest-index hit box.
- Macro undefined:
  - No colour registers are built.
  - `rgb = 3'b111` when `any_hit` is high, otherwise 0.

## Structure
- Package `bounce_pkg` holds:
  - FSM state enum (IDLE, STEP)
  - direction constants `DIR_POS`/`DIR_NEG`
  - functions for reset x/y of box i
- Sub-module `bounce_axis` is purely combinational.
  - Inputs: `p`, `dir`, `s`, `bound`.
  - Outputs: `p_next`, `dir_next`, `bounced`.
  - Instantiated twice (x and y) and shared across all boxes via the index mux.

## Test plan
- Reset, `N_BOX=2`:
  - Box0 at (16,16), `dx=0`; box1 at (64,48), `dx=1`.
  - All outputs 0.
- `speed=3`, one `frame_tick`:
  - Box0 moves to (19,19) and box1 to (61,51).
  - `busy` is high exactly 2 cycles.
  - No `bounce_pulse`.
- Box0 forced near the right edge (x=606, `dx=+`), `speed=4`:
  - x clamps to 608 and `dx` flips.
  - `bounce_pulse[0]` lasts 1 cycle.
  - Next frame: x = 604.
- Box at (2,1) moving `−`/`−`, `speed=2`:
  - Box moves to (0,0).
  - Both directions flip; `corner_pulse` and `bounce_pulse` both pulse.
- `pause=1`, or `speed=0`, then `frame_tick`: positions unchanged; `busy` stays low.
- Raster at (16,16) after reset: `box_hit=2'b01` one cycle later.
  - With `MULTI_BOUNCE_COLOR_EN`: `rgb=1`.
  - Without it: `rgb=7`.
  - With `MULTI_BOUNCE_COLOR_EN`, after box0's first bounce: `rgb=2`.

Source files
------------

// File: rtl/bounce_pkg.sv
// Shared types and helpers for the multi_bounce_box block: FSM state
// encoding, direction encoding and the reset placement of each box.
package bounce_pkg;

   // Update sequencer states
   typedef enum logic {
      IDLE = 1'b0,
      STEP = 1'b1
   } state_t;

   // Direction encoding shared by both axes
   localparam logic DIR_POS = 1'b0;
   localparam logic DIR_NEG = 1'b1;

   // Reset x of box i: boxes start on a diagonal so they never overlap at reset
   function automatic int unsigned reset_x(input int unsigned i);
      return 16 + 48 * i;
   endfunction

   // Reset y of box i
   function automatic int unsigned reset_y(input int unsigned i);
      return 16 + 32 * i;
   endfunction

endpackage

// File: rtl/bounce_axis.sv
// One-axis position stepper with edge reflection. Purely combinational; the
// top instantiates it once per axis and shares it across every box.
module bounce_axis
   import bounce_pkg::*;
#(
   parameter int COORD_W = 10,
   parameter int SPEED_W = 3
) (
   input  logic [COORD_W-1:0] p,
   input  logic               dir,
   input  logic [SPEED_W-1:0] s,
   input  logic [COORD_W-1:0] bound,
   output logic [COORD_W-1:0] p_next,
   output logic               dir_next,
   output logic               bounced
);

   // One extra bit so p + s can never wrap past the bound unnoticed
   localparam int XW = COORD_W + 1;

   logic [XW-1:0] p_ext;
   logic [XW-1:0] s_ext;
   logic [XW-1:0] sum;

   // Advance the position by s and reflect at 0 or at the bound
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      p_next   = p;
      dir_next = dir;
      bounced  = 1'b0;
      p_ext    = {1'b0, p};
      s_ext    = XW'(s);
      sum      = p_ext + s_ext;
      if (dir == DIR_POS) begin
         if (sum >= {1'b0, bound}) begin
            p_next   = bound;
            dir_next = DIR_NEG;
            bounced  = 1'b1;
         end else begin
            p_next = sum[COORD_W-1:0];
         end
      end else begin
         if (p_ext <= s_ext) begin
            p_next   = '0;
            dir_next = DIR_POS;
            bounced  = 1'b1;
         end else begin
            p_next = p - COORD_W'(s);
         end
      end
   end

endmodule

// File: rtl/multi_bounce_box.sv
// multi_bounce_box: N_BOX independent boxes bouncing on a VGA raster.
// One shared pair of bounce_axis steppers updates one box per cycle after a
// frame tick; per-box hit tests run every cycle against the live registers.
// Optional feature macro: MULTI_BOUNCE_COLOR_EN (per-box colour registers
// that advance on every bounce; otherwise any hit shows white).
module multi_bounce_box
   import bounce_pkg::*;
#(
   parameter int N_BOX   = 2,
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int BOX_W   = 32,
   parameter int BOX_H   = 32,
   parameter int COORD_W = 10,
   parameter int SPEED_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               frame_tick,
   input  logic               pause,
   input  logic [SPEED_W-1:0] speed,
   input  logic [COORD_W-1:0] hpos,
   input  logic [COORD_W-1:0] vpos,
   output logic [N_BOX-1:0]   box_hit,
   output logic               any_hit,
   output logic [2:0]         rgb,
   output logic [N_BOX-1:0]   bounce_pulse,
   output logic               corner_pulse,
   output logic               busy
);

   localparam int XW    = COORD_W + 1;
   localparam int IDX_W = (N_BOX > 1) ? $clog2(N_BOX) : 1;

   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_BOX - 1);
   localparam logic [COORD_W-1:0] X_BOUND  = COORD_W'(H_RES - BOX_W);
   localparam logic [COORD_W-1:0] Y_BOUND  = COORD_W'(V_RES - BOX_H);

   // Per-box state
   logic [COORD_W-1:0] x_q [N_BOX];
   logic [COORD_W-1:0] y_q [N_BOX];
   logic [N_BOX-1:0]   dx_q;
   logic [N_BOX-1:0]   dy_q;

   // Sequencer state
   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [SPEED_W-1:0] speed_q;

   // Shared stepping datapath
   logic [COORD_W-1:0] x_cur, y_cur, x_next, y_next;
   logic               dx_cur, dy_cur, dx_next, dy_next;
   logic               x_bounced, y_bounced;

   // Hit test results
   logic [N_BOX-1:0]   hit_c;
   logic [2:0]         rgb_c;

   // Select the box currently being stepped
   always_comb begin
      x_cur  = x_q[idx];
      y_cur  = y_q[idx];
      dx_cur = dx_q[idx];
      dy_cur = dy_q[idx];
   end

   bounce_axis #(
      .COORD_W (COORD_W),
      .SPEED_W (SPEED_W)
   ) u_axis_x (
      .p        (x_cur),
      .dir      (dx_cur),
      .s        (speed_q),
      .bound    (X_BOUND),
      .p_next   (x_next),
      .dir_next (dx_next),
      .bounced  (x_bounced)
   );

   bounce_axis #(
      .COORD_W (COORD_W),
      .SPEED_W (SPEED_W)
   ) u_axis_y (
      .p        (y_cur),
      .dir      (dy_cur),
      .s        (speed_q),
      .bound    (Y_BOUND),
      .p_next   (y_next),
      .dir_next (dy_next),
      .bounced  (y_bounced)
   );

   // Sequencer: on an accepted frame tick, step one box per cycle and pulse on reflections
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         speed_q      <= '0;
         busy         <= 1'b0;
         bounce_pulse <= '0;
         corner_pulse <= 1'b0;
         // NOTE: the box array is reset element by element because reset placement is visible behaviour, not a don't-care.
         for (int i = 0; i < N_BOX; i++) begin
            x_q[i]  <= COORD_W'(reset_x(i));
            y_q[i]  <= COORD_W'(reset_y(i));
            dx_q[i] <= i[0];
            dy_q[i] <= DIR_POS;
         end
      end else begin
         // NOTE: non-blocking everywhere here so every register sees the pre-edge values of the others.
         bounce_pulse <= '0;
         corner_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_tick && ena && !pause && (speed != '0)) begin
                  speed_q <= speed;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state   <= STEP;
               end
            end
            STEP: begin
               x_q[idx]          <= x_next;
               y_q[idx]          <= y_next;
               dx_q[idx]         <= dx_next;
               dy_q[idx]         <= dy_next;
               bounce_pulse[idx] <= x_bounced | y_bounced;
               corner_pulse      <= x_bounced & y_bounced;
               if (idx == LAST_IDX) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Raster-inside-box test for every box against the live position registers
   always_comb begin
      hit_c = '0;
      for (int i = 0; i < N_BOX; i++) begin
         hit_c[i] = (hpos >= x_q[i]) &&
                    ({1'b0, hpos} < ({1'b0, x_q[i]} + XW'(BOX_W))) &&
                    (vpos >= y_q[i]) &&
                    ({1'b0, vpos} < ({1'b0, y_q[i]} + XW'(BOX_H)));
      end
   end

`ifdef MULTI_BOUNCE_COLOR_EN
   logic [2:0] color_q [N_BOX];

   // Colour of each box advances (mod 8) every time that box reflects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BOX; i++) begin
            color_q[i] <= 3'(i + 1);
         end
      end else if ((state == STEP) && (x_bounced || y_bounced)) begin
         color_q[idx] <= color_q[idx] + 3'd1;
      end
   end

   // Lowest-index hit box wins the colour
   always_comb begin
      rgb_c = 3'b000;
      for (int i = N_BOX - 1; i >= 0; i--) begin
         if (hit_c[i]) begin
            rgb_c = color_q[i];
         end
      end
   end
`else
   // Without colour registers every box is drawn white
   always_comb begin
      rgb_c = (|hit_c) ? 3'b111 : 3'b000;
   end
`endif

   // Register the pixel outputs for the colour mux
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         box_hit <= '0;
         any_hit <= 1'b0;
         rgb     <= 3'b000;
      end else begin
         box_hit <= hit_c;
         any_hit <= |hit_c;
         rgb     <= rgb_c;
      end
   end

endmodule
